// File: rtl/rni_arlink_mc.sv
// ---------------------------------------------------------------------------
// rni_arlink_mc
//   Multi-channel AXI AR front end. Each channel buffers AR beats in a small
//   FIFO; an arbiter (round-robin or fixed priority) picks one burst at a time
//   and a two-state FSM splits it into 64-byte line requests.
//
// Parameters
//   NUM_CH      number of AR slave channels (1..8)
//   FIFO_DEPTH  per-channel AR buffer entries (power of 2, >=2)
//   ARB_MODE    0 = round-robin, 1 = fixed priority (ch0 highest)
//   ADDR_WIDTH  AR address width
//   ID_WIDTH    ARID width
//   CHW         channel index width
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   ARVALID/ARREADY[NUM_CH]      per-channel AR handshake
//   ARADDR/ARID/ARLEN/ARSIZE/ARBURST  flattened per-channel AR fields
//   req_valid_o/req_ready_i      line request handshake
//   req_addr_o/req_id_o/req_ch_o line address, ARID, source channel
//   req_first_o/req_last_o       first / last line of the current burst
// ---------------------------------------------------------------------------

// Per-channel AR buffer: plain circular FIFO, no bypass.
module rni_arlink_mc_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [PW:0]   r_cnt;
   logic [W-1:0]  r_mem [DEPTH];

   assign full_o  = (r_cnt == (PW+1)'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign dout_o  = r_mem[r_rp];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (push_i) r_wp <= r_wp + PW'(1);
         if (pop_i)  r_rp <= r_rp + PW'(1);
         case ({push_i, pop_i})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // storage needs no reset: occupancy is tracked by the pointers
   always_ff @(posedge clk_i) begin
      if (push_i) r_mem[r_wp] <= din_i;
   end
endmodule

module rni_arlink_mc #(
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int ARB_MODE   = 0,
   parameter int ADDR_WIDTH = 44,
   parameter int ID_WIDTH   = 11,
   parameter int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_CH-1:0]            ARVALID,
   output logic [NUM_CH-1:0]            ARREADY,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] ARADDR,
   input  logic [NUM_CH*ID_WIDTH-1:0]   ARID,
   input  logic [NUM_CH*8-1:0]          ARLEN,
   input  logic [NUM_CH*3-1:0]          ARSIZE,
   input  logic [NUM_CH*2-1:0]          ARBURST,
   output logic                         req_valid_o,
   input  logic                         req_ready_i,
   output logic [ADDR_WIDTH-1:0]        req_addr_o,
   output logic [ID_WIDTH-1:0]          req_id_o,
   output logic [CHW-1:0]               req_ch_o,
   output logic                         req_first_o,
   output logic                         req_last_o
);
   // entry layout: {burst, size, len, id, addr}
   localparam int EW = ADDR_WIDTH + ID_WIDTH + 13;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEG  = 1'b1;

   localparam logic [1:0] M_FIXED = 2'd0;
   localparam logic [1:0] M_INCR  = 2'd1;
   localparam logic [1:0] M_WRAP  = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LINE  = ADDR_WIDTH'(64);
   localparam logic [ADDR_WIDTH-1:0] LMASK = ~ADDR_WIDTH'(63);

   logic [NUM_CH-1:0]         w_full;
   logic [NUM_CH-1:0]         w_empty;
   logic [NUM_CH-1:0]         w_push;
   logic [NUM_CH-1:0]         w_pop;
   logic [NUM_CH-1:0][EW-1:0] w_head;

   logic [0:0]            r_state;
   logic [CHW-1:0]        r_rr;
   logic [CHW-1:0]        r_ch;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_wmask;
   logic [ID_WIDTH-1:0]   r_id;
   logic [1:0]            r_mode;
   logic [9:0]            r_cnt;
   logic                  r_first;
   logic                  r_last;

   logic w_acc;
   logic w_last_acc;

   assign w_acc      = (r_state == S_SEG) & req_ready_i;
   assign w_last_acc = w_acc & r_last;

   // ---------------- per-channel buffers ----------------
   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_ch
         logic [EW-1:0] w_din;
         assign w_din = {ARBURST[c*2 +: 2], ARSIZE[c*3 +: 3], ARLEN[c*8 +: 8],
                         ARID[c*ID_WIDTH +: ID_WIDTH],
                         ARADDR[c*ADDR_WIDTH +: ADDR_WIDTH]};
         assign ARREADY[c] = ~w_full[c];
         assign w_push[c]  = ARVALID[c] & ~w_full[c];
         // the head stays buffered for the whole burst; it leaves with its last line
         assign w_pop[c]   = w_last_acc & (r_ch == CHW'(c));

         rni_arlink_mc_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (w_push[c]),
            .pop_i   (w_pop[c]),
            .din_i   (w_din),
            .dout_o  (w_head[c]),
            .full_o  (w_full[c]),
            .empty_o (w_empty[c])
         );
      end
   endgenerate

   // ---------------- arbiter ----------------
   logic           w_any;
   logic [CHW-1:0] w_grant;

   assign w_any = |(~w_empty);

   always_comb begin
      int  idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      w_grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (ARB_MODE == 1) ? i : int'(r_rr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && !w_empty[idx]) begin
            found   = 1'b1;
            w_grant = CHW'(idx);
         end
      end
   end

   // ---------------- burst decode of the granted head ----------------
   logic [EW-1:0]         w_sel;
   logic [ADDR_WIDTH-1:0] w_h_addr;
   logic [ID_WIDTH-1:0]   w_h_id;
   logic [7:0]            w_h_len;
   logic [2:0]            w_h_size;
   logic [1:0]            w_h_burst;
   logic [16:0]           w_bytes;
   logic [16:0]           w_span;
   logic                  w_wrap_ok;
   logic [1:0]            w_mode;
   logic [10:0]           w_nseg;
   logic [9:0]            w_cnt_ld;
   logic [ADDR_WIDTH-1:0] w_wmask;

   assign w_sel     = w_head[w_grant];
   assign w_h_addr  = w_sel[ADDR_WIDTH-1:0];
   assign w_h_id    = w_sel[ADDR_WIDTH +: ID_WIDTH];
   assign w_h_len   = w_sel[ADDR_WIDTH+ID_WIDTH +: 8];
   assign w_h_size  = w_sel[ADDR_WIDTH+ID_WIDTH+8 +: 3];
   assign w_h_burst = w_sel[ADDR_WIDTH+ID_WIDTH+11 +: 2];

   // max burst is 256 beats of 128 bytes = 2^15 bytes
   assign w_bytes   = (17'(w_h_len) + 17'd1) << w_h_size;
   // last byte offset relative to the first line
   assign w_span    = 17'(w_h_addr[5:0]) + w_bytes - 17'd1;
   assign w_wmask   = ADDR_WIDTH'(w_bytes - 17'd1);
   // WRAP is only legal for 2/4/8/16 beats; anything else degrades to INCR
   assign w_wrap_ok = (w_h_burst == 2'b10) &&
                      ((w_h_len == 8'd1) || (w_h_len == 8'd3) ||
                       (w_h_len == 8'd7) || (w_h_len == 8'd15));

   always_comb begin
      w_mode = M_INCR;
      w_nseg = 11'(w_span >> 6) + 11'd1;
      if (w_h_burst == 2'b00) begin
         w_mode = M_FIXED;
         w_nseg = 11'(w_h_len) + 11'd1;
      end else if (w_wrap_ok) begin
         w_mode = M_WRAP;
         // a container that fits in one line is a single request at ARADDR
         w_nseg = (w_bytes <= 17'd64) ? 11'd1 : 11'(w_bytes >> 6);
      end
   end

   assign w_cnt_ld = 10'(w_nseg - 11'd1);

   // ---------------- next line address ----------------
   logic [ADDR_WIDTH-1:0] w_next_addr;

   always_comb begin
      case (r_mode)
         M_FIXED: w_next_addr = r_addr;
         // stay inside the container, wrapping its line offset
         M_WRAP:  w_next_addr = (r_addr & ~r_wmask) |
                                ((r_addr + LINE) & r_wmask & LMASK);
         default: w_next_addr = (r_addr & LMASK) + LINE;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_ch    <= '0;
         r_addr  <= '0;
         r_wmask <= '0;
         r_id    <= '0;
         r_mode  <= M_INCR;
         r_cnt   <= '0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_SEG;
                  r_ch    <= w_grant;
                  r_addr  <= w_h_addr;
                  r_id    <= w_h_id;
                  r_mode  <= w_mode;
                  r_wmask <= w_wmask;
                  r_cnt   <= w_cnt_ld;
                  r_first <= 1'b1;
                  r_last  <= (w_cnt_ld == 10'd0);
               end
            end
            default: begin
               if (w_acc) begin
                  if (r_last) begin
                     r_state <= S_IDLE;
                     r_first <= 1'b0;
                     r_last  <= 1'b0;
                     r_rr    <= (r_ch == CHW'(NUM_CH - 1)) ? '0 : r_ch + CHW'(1);
                  end else begin
                     r_cnt   <= r_cnt - 10'd1;
                     r_addr  <= w_next_addr;
                     r_first <= 1'b0;
                     r_last  <= (r_cnt == 10'd1);
                  end
               end
            end
         endcase
      end
   end

   assign req_valid_o = (r_state == S_SEG);
   assign req_addr_o  = r_addr;
   assign req_id_o    = r_id;
   assign req_ch_o    = r_ch;
   assign req_first_o = r_first;
   assign req_last_o  = r_last;
endmodule

// File: tb/tb_rni_arlink_mc.sv
// ---------------------------------------------------------------------------
// tb_rni_arlink_mc
//   Directed bench for rni_arlink_mc. Two instances share clock/reset/ready:
//   u_rr (round-robin) carries every scenario, u_fp (fixed priority) only the
//   arbitration one. Expected line requests are queued at issue time and a
//   monitor per instance pops and compares on each accepted request.
// ---------------------------------------------------------------------------
module tb_rni_arlink_mc;
   typedef struct packed {
      logic [43:0] addr;
      logic [10:0] id;
      logic [0:0]  ch;
      logic        fst;
      logic        lst;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;

   logic [1:0]  a_arvalid = '0, b_arvalid = '0;
   logic [1:0]  a_arready, b_arready;
   logic [87:0] a_araddr = '0, b_araddr = '0;
   logic [21:0] a_arid = '0, b_arid = '0;
   logic [15:0] a_arlen = '0, b_arlen = '0;
   logic [5:0]  a_arsize = '0, b_arsize = '0;
   logic [3:0]  a_arburst = '0, b_arburst = '0;
   logic        a_valid, b_valid;
   logic [43:0] a_addr, b_addr;
   logic [10:0] a_id, b_id;
   logic [0:0]  a_ch, b_ch;
   logic        a_first, b_first, a_last, b_last;

   int checks = 0;
   int failures = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;

   rni_arlink_mc #(.NUM_CH(2), .FIFO_DEPTH(2), .ARB_MODE(0), .ADDR_WIDTH(44), .ID_WIDTH(11)) u_rr (
      .clk_i(clk), .rst_i(rst), .ARVALID(a_arvalid), .ARREADY(a_arready),
      .ARADDR(a_araddr), .ARID(a_arid), .ARLEN(a_arlen), .ARSIZE(a_arsize), .ARBURST(a_arburst),
      .req_valid_o(a_valid), .req_ready_i(rdy), .req_addr_o(a_addr), .req_id_o(a_id),
      .req_ch_o(a_ch), .req_first_o(a_first), .req_last_o(a_last));

   rni_arlink_mc #(.NUM_CH(2), .FIFO_DEPTH(2), .ARB_MODE(1), .ADDR_WIDTH(44), .ID_WIDTH(11)) u_fp (
      .clk_i(clk), .rst_i(rst), .ARVALID(b_arvalid), .ARREADY(b_arready),
      .ARADDR(b_araddr), .ARID(b_arid), .ARLEN(b_arlen), .ARSIZE(b_arsize), .ARBURST(b_arburst),
      .req_valid_o(b_valid), .req_ready_i(rdy), .req_addr_o(b_addr), .req_id_o(b_id),
      .req_ch_o(b_ch), .req_first_o(b_first), .req_last_o(b_last));

   function automatic exp_t mk(input logic [43:0] a, input logic [10:0] id,
                               input logic ch, input logic f, input logic l);
      exp_t e;
      e.addr = a; e.id = id; e.ch = ch; e.fst = f; e.lst = l;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // scoreboard monitors: outputs are sampled on the falling edge
   exp_t ea, aa, eb, ab;
   always @(negedge clk) begin
      if (a_valid && rdy) begin
         checks++;
         aa = mk(a_addr, a_id, a_ch, a_first, a_last);
         if (qa.size() == 0) begin
            failures++;
            $display("FAIL rr_unexpected_req actual addr=%0h id=%0h required none", a_addr, a_id);
         end else begin
            ea = qa.pop_front();
            if (aa !== ea) begin
              failures++;
              $display("FAIL rr_req actual addr=%0h id=%0h ch=%0d f=%0b l=%0b required addr=%0h id=%0h ch=%0d f=%0b l=%0b",
                       aa.addr, aa.id, aa.ch, aa.fst, aa.lst, ea.addr, ea.id, ea.ch, ea.fst, ea.lst);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_valid && rdy) begin
         checks++;
         ab = mk(b_addr, b_id, b_ch, b_first, b_last);
         if (qb.size() == 0) begin
            failures++;
            $display("FAIL fp_unexpected_req actual addr=%0h id=%0h required none", b_addr, b_id);
         end else begin
            eb = qb.pop_front();
            if (ab !== eb) begin
              failures++;
              $display("FAIL fp_req actual addr=%0h id=%0h ch=%0d f=%0b l=%0b required addr=%0h id=%0h ch=%0d f=%0b l=%0b",
                       ab.addr, ab.id, ab.ch, ab.fst, ab.lst, eb.addr, eb.id, eb.ch, eb.fst, eb.lst);
            end
         end
      end
   end

   // call at posedge+1; returns at posedge+1 right after the handshake edge
   task automatic ar_push(input bit dut, input int c, input logic [43:0] addr,
                          input logic [10:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      if (!dut) begin
         a_araddr[c*44 +: 44] = addr; a_arid[c*11 +: 11] = id;
         a_arlen[c*8 +: 8] = len; a_arsize[c*3 +: 3] = size; a_arburst[c*2 +: 2] = burst;
         a_arvalid[c] = 1'b1;
      end else begin
         b_araddr[c*44 +: 44] = addr; b_arid[c*11 +: 11] = id;
         b_arlen[c*8 +: 8] = len; b_arsize[c*3 +: 3] = size; b_arburst[c*2 +: 2] = burst;
         b_arvalid[c] = 1'b1;
      end
      while (!done && n < 40) begin
         if ((!dut && a_arready[c]) || (dut && b_arready[c])) done = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      if (!dut) a_arvalid[c] = 1'b0;
      else      b_arvalid[c] = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL ar_push_timeout actual=no_handshake required=handshake ch=%0d", c);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() + qb.size()) != 0 && n < 80) begin cyc(1); n++; end
      chk("drain_left", 64'(qa.size() + qb.size()), 64'd0);
      cyc(3);
   endtask

   initial begin
      int n;
      cyc(3);
      // reset state
      chk("rst_valid", 64'(a_valid), 64'd0);
      chk("rst_arready", 64'(a_arready), 64'd3);
      chk("rst_first_last", 64'({a_first, a_last}), 64'd0);
      chk("rst_fp_valid", 64'(b_valid), 64'd0);
      rst = 1'b0;
      cyc(2);

      // INCR crossing a line, latency from handshake
      qa.push_back(mk(44'h1030, 11'd5, 1'b0, 1'b1, 1'b0));
      qa.push_back(mk(44'h1040, 11'd5, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'h1030, 11'd5, 8'd3, 3'd4, 2'b01);
      chk("lat_t1_valid", 64'(a_valid), 64'd0);
      cyc(1);
      chk("lat_t2_valid", 64'(a_valid), 64'd1);
      drain();

      // FIXED with a 5-cycle stall
      rdy = 1'b0;
      qa.push_back(mk(44'h2004, 11'd6, 1'b0, 1'b1, 1'b0));
      qa.push_back(mk(44'h2004, 11'd6, 1'b0, 1'b0, 1'b0));
      qa.push_back(mk(44'h2004, 11'd6, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'h2004, 11'd6, 8'd2, 3'd2, 2'b00);
      n = 0;
      while (!a_valid && n < 10) begin cyc(1); n++; end
      repeat (5) begin
         chk("stall_hold", 64'({a_valid, a_addr, a_first, a_last}), {17'd0, 1'b1, 44'h2004, 1'b1, 1'b0});
         cyc(1);
      end
      rdy = 1'b1;
      drain();

      // WRAP 128-byte container on ch1
      qa.push_back(mk(44'h30C0, 11'd7, 1'b1, 1'b1, 1'b0));
      qa.push_back(mk(44'h3080, 11'd7, 1'b1, 1'b0, 1'b1));
      ar_push(0, 1, 44'h30C0, 11'd7, 8'd7, 3'd4, 2'b10);
      drain();

      // decode boundaries
      qa.push_back(mk(44'h5010, 11'd8, 1'b0, 1'b1, 1'b0));
      qa.push_back(mk(44'h5040, 11'd8, 1'b0, 1'b0, 1'b0));
      qa.push_back(mk(44'h5080, 11'd8, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'h5010, 11'd8, 8'd15, 3'd3, 2'b01);
      qa.push_back(mk(44'h6020, 11'd9, 1'b0, 1'b1, 1'b0));   // reserved burst -> INCR
      qa.push_back(mk(44'h6040, 11'd9, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'h6020, 11'd9, 8'd1, 3'd5, 2'b11);
      qa.push_back(mk(44'h7000, 11'd10, 1'b0, 1'b1, 1'b0));  // illegal WRAP length -> INCR
      qa.push_back(mk(44'h7040, 11'd10, 1'b0, 1'b0, 1'b0));
      qa.push_back(mk(44'h7080, 11'd10, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'h7000, 11'd10, 8'd2, 3'd6, 2'b10);
      qa.push_back(mk(44'h8014, 11'd11, 1'b0, 1'b1, 1'b1));  // WRAP within one line
      ar_push(0, 0, 44'h8014, 11'd11, 8'd3, 3'd2, 2'b10);
      qa.push_back(mk(44'hFFF_FFFF_FFC0, 11'd12, 1'b0, 1'b1, 1'b0)); // address rolls over
      qa.push_back(mk(44'h0, 11'd12, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'hFFF_FFFF_FFC0, 11'd12, 8'd1, 3'd6, 2'b01);
      qa.push_back(mk(44'hA0C0, 11'd13, 1'b0, 1'b1, 1'b0));  // WRAP 256 starting mid
      qa.push_back(mk(44'hA000, 11'd13, 1'b0, 1'b0, 1'b0));
      qa.push_back(mk(44'hA040, 11'd13, 1'b0, 1'b0, 1'b0));
      qa.push_back(mk(44'hA080, 11'd13, 1'b0, 1'b0, 1'b1));
      ar_push(0, 0, 44'hA0C0, 11'd13, 8'd3, 3'd6, 2'b10);
      drain();

      // ARREADY back-pressure on ch1
      rdy = 1'b0;
      qa.push_back(mk(44'hB000, 11'd20, 1'b1, 1'b1, 1'b1));
      qa.push_back(mk(44'hB040, 11'd21, 1'b1, 1'b1, 1'b1));
      qa.push_back(mk(44'hB080, 11'd22, 1'b1, 1'b1, 1'b1));
      ar_push(0, 1, 44'hB000, 11'd20, 8'd0, 3'd6, 2'b01);
      ar_push(0, 1, 44'hB040, 11'd21, 8'd0, 3'd6, 2'b01);
      chk("bp_full", 64'(a_arready[1]), 64'd0);
      a_araddr[44 +: 44] = 44'hB080; a_arid[11 +: 11] = 11'd22;
      a_arlen[8 +: 8] = 8'd0; a_arsize[3 +: 3] = 3'd6; a_arburst[2 +: 2] = 2'b01;
      a_arvalid[1] = 1'b1;
      cyc(1);
      chk("bp_still_full", 64'(a_arready[1]), 64'd0);
      rdy = 1'b1;
      chk("bp_full_at_accept", 64'(a_arready[1]), 64'd0);
      cyc(1);
      chk("bp_rise", 64'(a_arready[1]), 64'd1);
      cyc(1);
      a_arvalid[1] = 1'b0;
      drain();

      // arbitration: both channels loaded with single-line reads
      rdy = 1'b0;
      qa.push_back(mk(44'hC000, 11'd30, 1'b0, 1'b1, 1'b1));
      qa.push_back(mk(44'hD000, 11'd31, 1'b1, 1'b1, 1'b1));
      qa.push_back(mk(44'hC040, 11'd32, 1'b0, 1'b1, 1'b1));
      qa.push_back(mk(44'hD040, 11'd33, 1'b1, 1'b1, 1'b1));
      qb.push_back(mk(44'hC000, 11'd30, 1'b0, 1'b1, 1'b1));
      qb.push_back(mk(44'hC040, 11'd32, 1'b0, 1'b1, 1'b1));
      qb.push_back(mk(44'hD000, 11'd31, 1'b1, 1'b1, 1'b1));
      qb.push_back(mk(44'hD040, 11'd33, 1'b1, 1'b1, 1'b1));
      for (int d = 0; d < 2; d++) begin
         ar_push(d[0], 0, 44'hC000, 11'd30, 8'd0, 3'd6, 2'b01);
         ar_push(d[0], 1, 44'hD000, 11'd31, 8'd0, 3'd6, 2'b01);
         ar_push(d[0], 0, 44'hC040, 11'd32, 8'd0, 3'd6, 2'b01);
         ar_push(d[0], 1, 44'hD040, 11'd33, 8'd0, 3'd6, 2'b01);
      end
      rdy = 1'b1;
      drain();

      // reset during segment 2 of a 4-line burst
      qa.push_back(mk(44'h9000, 11'd40, 1'b0, 1'b1, 1'b0));
      qa.push_back(mk(44'h9040, 11'd40, 1'b0, 1'b0, 1'b0));
      ar_push(0, 0, 44'h9000, 11'd40, 8'd3, 3'd6, 2'b01);
      cyc(3);
      chk("mid_rst_seg2_addr", 64'(a_addr), 64'h9080);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(a_valid), 64'd0);
      chk("mid_rst_arready", 64'(a_arready), 64'd3);
      chk("mid_rst_first_last", 64'({a_first, a_last}), 64'd0);
      cyc(2);
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         if (a_valid) n++;
         cyc(1);
      end
      chk("post_rst_no_stale", 64'(n), 64'd0);
      chk("post_rst_queue", 64'(qa.size() + qb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rni_arlink_mc.md
RNI_ARLINK_MC -- requirements
Module: rni_arlink_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of AXI AR slave channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, per-channel AR buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority with ch0 highest.
REQ-004 SHALL have parameter ADDR_WIDTH, default 44, AR address width.
REQ-005 SHALL have parameter ID_WIDTH, default 11, ARID width.
REQ-006 SHALL have parameter CHW, default $clog2(NUM_CH) (min 1), channel index width.
REQ-007 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port ARVALID, input, NUM_CH, per-channel AR valid.
REQ-010 SHALL have port ARREADY, output, NUM_CH, per-channel AR ready.
REQ-011 SHALL have ports ARADDR/ARID/ARLEN/ARSIZE/ARBURST, inputs, NUM_CH*{ADDR_WIDTH, ID_WIDTH, 8, 3, 2}, flattened with channel c at slice c.
REQ-012 SHALL have port req_valid_o, output, 1, line request valid.
REQ-013 SHALL have port req_ready_i, input, 1, downstream accept (allocator not busy).
REQ-014 SHALL have ports req_addr_o/req_id_o/req_ch_o, outputs, ADDR_WIDTH/ID_WIDTH/CHW, request address, ID and source channel.
REQ-015 SHALL have ports req_first_o/req_last_o, outputs, 1 each, first and last request of the current AXI burst.

Function
REQ-016 Each channel SHALL buffer AR beats in its own FIFO_DEPTH-entry FIFO, with no bypass.
REQ-017 ARREADY[c] SHALL equal ~full[c]; push = ARVALID[c] & ARREADY[c]; a push into a non-full FIFO in the same cycle as a pop SHALL perform both.
REQ-018 The FSM SHALL have two states, IDLE and SEG.
REQ-019 In IDLE with any FIFO non-empty, the FSM SHALL grant one channel per ARB_MODE, latch that head entry's fields into working registers and go to SEG.
REQ-020 Round-robin SHALL search from pointer rr_ptr upward with wrap; after the grant's last segment is accepted, rr_ptr SHALL become grant+1 modulo NUM_CH.
REQ-021 req_valid_o SHALL be 1 exactly while in SEG; req_* outputs SHALL be registered and stable while req_valid_o & ~req_ready_i.
REQ-022 Latency SHALL be: AR handshake at cycle t -> FIFO non-empty at t+1 -> req_valid_o at t+2, when idle.
REQ-023 INCR bursts: total bytes B = (ARLEN+1)<<ARSIZE; segment count N = ((addr[5:0]+B-1)>>6)+1; segment 0 address = ARADDR; segment k>0 address = (ARADDR & ~63) + 64*k.
REQ-024 FIXED bursts: N = ARLEN+1, every segment address = ARADDR.
REQ-025 WRAP bursts: container W = B; base = ARADDR & ~(W-1); if W<=64, N=1 at ARADDR; else N=W/64, starting at the line holding ARADDR and wrapping from base+W-64 back to base.
REQ-026 The remaining-segment counter SHALL be 10 bits, loaded with N-1 and decremented on each accept.
REQ-027 req_first_o SHALL be 1 on segment 0; req_last_o SHALL be 1 when the counter is 0.
REQ-028 On accept of the last segment, the granted FIFO SHALL pop in that cycle and the FSM SHALL return to IDLE, giving one bubble cycle between bursts.
REQ-029 ARSIZE values above 7, reserved ARBURST=3, and ARSIZE/ARLEN combinations that are illegal for WRAP are undefined; they SHALL be treated as INCR without hang.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_WIDTH.

Reset
REQ-031 While rst_i is high, all FIFOs SHALL be empty, the FSM SHALL be IDLE, rr_ptr SHALL be 0, the counter SHALL be 0, req_valid_o/req_first_o/req_last_o SHALL be 0, and ARREADY SHALL be all-1.
REQ-032 Reset asserted mid-burst SHALL discard all buffered and in-flight requests, with no further req_valid_o until new AR input arrives.

Verification
REQ-033 The bench SHALL cover: ch0 INCR ARADDR=0x1030, ARLEN=3, ARSIZE=4 -> 2 reqs at 0x1030 (first) and 0x1040 (last); req_valid_o high 2 cycles after the handshake.
REQ-034 The bench SHALL cover: ch0 FIXED ARADDR=0x2004, ARLEN=2, req_ready_i=0 for 5 cycles -> 3 reqs all at 0x2004; outputs stable while stalled.
REQ-035 The bench SHALL cover: WRAP ARADDR=0x30C0, ARLEN=7, ARSIZE=4 (W=128) -> 2 reqs at 0x30C0 then 0x3080.
REQ-036 The bench SHALL cover: ARB_MODE=0, both channels continuously loaded with single-line reads -> grants alternate ch0, ch1, ch0...; with ARB_MODE=1 -> ch0 only until it is empty.
REQ-037 The bench SHALL cover: FIFO_DEPTH=2, req_ready_i=0 with 3 ARVALIDs on ch1 -> ARREADY[1] drops after 2 accepted; it rises the cycle after the first burst completes.
REQ-038 The bench SHALL cover: rst_i pulsed during segment 2 of a 4-segment burst -> req_valid_o is 0 in the same cycle, ARREADY is all-1, and no stale request appears afterwards.
